// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: request/grant bundle between the requester front-ends
// (master side) and the round-robin memory arbiter (slave side).
// Optional build macro: MEM_ARB_URGENT_EN adds the per-channel urgent vector.
interface mem_rr_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] req;
  logic              lock;
`ifdef MEM_ARB_URGENT_EN
  logic [NUM_CH-1:0] urgent;
`endif
  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic              preempted;

`ifdef MEM_ARB_URGENT_EN
  modport master (
    output req, lock, urgent,
    input  grant, grant_idx, grant_valid, preempted
  );
  modport slave (
    input  req, lock, urgent,
    output grant, grant_idx, grant_valid, preempted
  );
`else
  modport master (
    output req, lock,
    input  grant, grant_idx, grant_valid, preempted
  );
  modport slave (
    input  req, lock,
    output grant, grant_idx, grant_valid, preempted
  );
`endif
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter for NUM_CH memory requesters with a
// hold quantum (MAX_HOLD, 0 = unlimited) and a lock input that defers
// quantum preemption during atomic bursts. All outputs are registered.
// Optional build macro: MEM_ARB_URGENT_EN lets urgent requesters take the
// port from a non-urgent owner on the next edge.
module mem_rr_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  mem_rr_arbiter_if.slave arb
);

  localparam int               HC_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NUM_CH - 1);

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of mask scanning upward from last+1 with wrap-around.
  function automatic pick_t rr_pick(input logic [NUM_CH-1:0] mask,
                                    input logic [IDX_W-1:0]  last);
    pick_t            p;
    logic [IDX_W-1:0] c;
    p.found = 1'b0;
    p.idx   = last;
    c       = last;
    for (int i = 0; i < NUM_CH; i++) begin
      if (c == IDX_W'(NUM_CH - 1)) c = '0;
      else                         c = c + IDX_W'(1);
      if (!p.found && mask[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Saturating hold counter; pinned at zero when the quantum is disabled.
  function automatic logic [HC_W-1:0] hold_inc(input logic [HC_W-1:0] h);
    if (MAX_HOLD == 0)   return '0;
    if (h == HOLD_LAST)  return h;
    return h + HC_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              valid_q, valid_d;
  logic              pre_q, pre_d;
  logic              preempt_ev;

  logic [NUM_CH-1:0] owner_oh;
  logic              owner_req;
  logic [NUM_CH-1:0] req_oth;
  logic [NUM_CH-1:0] cand_oth;
  logic [NUM_CH-1:0] cand_idle;
  logic              urg_take;
  logic              quantum_up;
  pick_t             pick_idle;
  pick_t             pick_oth;

  assign owner_oh   = onehot(idx_q);
  assign owner_req  = |(arb.req & owner_oh);
  assign req_oth    = arb.req & ~owner_oh;
  assign quantum_up = (MAX_HOLD > 0) && (hold_q == HOLD_LAST);

`ifdef MEM_ARB_URGENT_EN
  // Urgent requesters narrow the candidate set whenever any are pending.
  logic [NUM_CH-1:0] urg_oth;
  logic [NUM_CH-1:0] urg_idle;
  assign urg_oth   = req_oth & arb.urgent;
  assign urg_idle  = arb.req & arb.urgent;
  assign cand_oth  = (|urg_oth)  ? urg_oth  : req_oth;
  assign cand_idle = (|urg_idle) ? urg_idle : arb.req;
  assign urg_take  = (|urg_oth) && !(|(arb.urgent & owner_oh)) && !arb.lock;
`else
  assign cand_oth  = req_oth;
  assign cand_idle = arb.req;
  assign urg_take  = 1'b0;
`endif

  assign pick_idle = rr_pick(cand_idle, ptr_q);
  assign pick_oth  = rr_pick(cand_oth, idx_q);

  // State register: arbitration state, owner, pointer, hold count and outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ptr_q   <= PTR_RST;
      hold_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      pre_q   <= pre_d;
    end
  end

  // Next-state: grant, release hand-off, quantum/urgent preemption, hold count.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    preempt_ev = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_idle.found) begin
          state_d = S_OWNED;
          idx_d   = pick_idle.idx;
          ptr_d   = pick_idle.idx;
          hold_d  = '0;
        end
      end
      S_OWNED: begin
        if (!owner_req) begin
          // Release wins over a coinciding quantum expiry: no preempt pulse.
          if (pick_oth.found) begin
            idx_d  = pick_oth.idx;
            ptr_d  = pick_oth.idx;
            hold_d = '0;
          end else begin
            state_d = S_IDLE;
            hold_d  = '0;
          end
        end else if (!(|cand_oth)) begin
          hold_d = hold_inc(hold_q);
        end else if (urg_take || (quantum_up && !arb.lock)) begin
          idx_d      = pick_oth.idx;
          ptr_d      = pick_oth.idx;
          hold_d     = '0;
          preempt_ev = 1'b1;
        end else begin
          hold_d = hold_inc(hold_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode of the next state, registered in the state register.
  always_comb begin
    valid_d = (state_d == S_OWNED);
    grant_d = '0;
    if (valid_d) grant_d = onehot(idx_d);
    pre_d   = preempt_ev;
  end

  assign arb.grant       = grant_q;
  assign arb.grant_idx   = idx_q;
  assign arb.grant_valid = valid_q;
  assign arb.preempted   = pre_q;

  // Grant vector is one-hot and matches grant_idx exactly while valid.
  a_grant_onehot: assert property (@(posedge sys_clk) disable iff (sys_rst)
    valid_q |-> (grant_q == onehot(idx_q)));

  // No grant bits and no preempt pulse while idle.
  a_idle_quiet: assert property (@(posedge sys_clk) disable iff (sys_rst)
    !valid_q |-> (grant_q == '0) && !pre_q);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed vectors for the round-robin memory arbiter,
// one instance without quantum (MAX_HOLD=0) and one with MAX_HOLD=16.
module tb_mem_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  mem_rr_arbiter_if #(.NUM_CH(4)) bus0  ();
  mem_rr_arbiter_if #(.NUM_CH(4)) bus16 ();

  mem_rr_arbiter #(.NUM_CH(4), .MAX_HOLD(0)) dut0 (
    .sys_clk (clk),
    .sys_rst (rst),
    .arb     (bus0)
  );

  mem_rr_arbiter #(.NUM_CH(4), .MAX_HOLD(16)) dut16 (
    .sys_clk (clk),
    .sys_rst (rst),
    .arb     (bus16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus0.req   = '0;
    bus0.lock  = 1'b0;
    bus16.req  = '0;
    bus16.lock = 1'b0;
`ifdef MEM_ARB_URGENT_EN
    bus0.urgent  = '0;
    bus16.urgent = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  int         exp_seq [5] = '{0, 1, 2, 3, 0};
  logic [3:0] r;
  logic [1:0] prev;
  int         bad;
  int         pre_cnt;
  int         exp_own;
  int         exp_pre;

  initial begin
    // Reset state on both instances.
    do_reset();
    chk("rst_grant0",  32'(bus0.grant),        32'(0));
    chk("rst_idx0",    32'(bus0.grant_idx),    32'(0));
    chk("rst_valid0",  32'(bus0.grant_valid),  32'(0));
    chk("rst_pre0",    32'(bus0.preempted),    32'(0));
    chk("rst_grant16", 32'(bus16.grant),       32'(0));
    chk("rst_valid16", 32'(bus16.grant_valid), 32'(0));

    // Rotation 0,1,2,3,0 without quantum; each owner releases after 3 cycles.
    bus0.req = 4'b1111;
    #1;
    chk("t1_valid_before_edge", 32'(bus0.grant_valid), 32'(0));
    tick();
    chk("t1_first_idx",   32'(bus0.grant_idx),   32'(0));
    chk("t1_first_valid", 32'(bus0.grant_valid), 32'(1));
    chk("t1_first_grant", 32'(bus0.grant),       32'(4'b0001));
    prev = 2'd0;
    for (int s = 1; s <= 4; s++) begin
      tick();
      tick();
      chk($sformatf("t1_hold_s%0d", s), 32'(bus0.grant_idx), 32'(prev));
      r        = 4'b1111;
      r[prev]  = 1'b0;
      bus0.req = r;
      tick();
      chk($sformatf("t1_idx_s%0d", s),   32'(bus0.grant_idx),   32'(exp_seq[s]));
      chk($sformatf("t1_grant_s%0d", s), 32'(bus0.grant),       32'(4'b0001 << exp_seq[s]));
      chk($sformatf("t1_valid_s%0d", s), 32'(bus0.grant_valid), 32'(1));
      chk($sformatf("t1_pre_s%0d", s),   32'(bus0.preempted),   32'(0));
      bus0.req = 4'b1111;
      prev     = 2'(exp_seq[s]);
    end
    bus0.req = '0;

    // Lone requester keeps the port indefinitely, no preemption.
    do_reset();
    bus16.req = 4'b0001;
    bad       = 0;
    pre_cnt   = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus16.grant !== 4'b0001) bad++;
      if (bus16.preempted !== 1'b0) pre_cnt++;
    end
    chk("t2_grant_stable", 32'(bad),     32'(0));
    chk("t2_no_preempt",   32'(pre_cnt), 32'(0));

    // Two requesters alternate every 16 cycles with a preempt pulse.
    do_reset();
    bus16.req = 4'b0011;
    for (int c = 1; c <= 33; c++) begin
      tick();
      exp_own = ((c - 1) / 16) % 2;
      exp_pre = (c > 1 && ((c - 1) % 16) == 0) ? 1 : 0;
      chk($sformatf("t3_idx_c%0d", c), 32'(bus16.grant_idx), 32'(exp_own));
      chk($sformatf("t3_pre_c%0d", c), 32'(bus16.preempted), 32'(exp_pre));
    end
    chk("t3_grant_final", 32'(bus16.grant), 32'(4'b0001));

    // Lock defers preemption; switch to channel 1 on the edge after lock falls.
    do_reset();
    bus16.req = 4'b0100;
    tick();
    chk("t4_owner2", 32'(bus16.grant_idx), 32'(2));
    bus16.req  = 4'b0110;
    bus16.lock = 1'b1;
    bad        = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus16.grant_idx !== 2'd2 || bus16.preempted !== 1'b0) bad++;
    end
    chk("t4_locked_hold", 32'(bad), 32'(0));
    bus16.lock = 1'b0;
    tick();
    chk("t4_switch_idx", 32'(bus16.grant_idx), 32'(1));
    chk("t4_switch_pre", 32'(bus16.preempted), 32'(1));
    bus16.req = '0;
    tick();
    chk("t4_idle_valid", 32'(bus16.grant_valid), 32'(0));
    chk("t4_idle_grant", 32'(bus16.grant),       32'(0));
    chk("t4_idle_idx",   32'(bus16.grant_idx),   32'(1));
    chk("t4_idle_pre",   32'(bus16.preempted),   32'(0));

    // Release on the quantum-expiry edge counts as a release.
    do_reset();
    bus16.req = 4'b1000;
    tick();
    chk("t5_owner3", 32'(bus16.grant_idx), 32'(3));
    bus16.req = 4'b1001;
    repeat (15) tick();
    chk("t5_still3", 32'(bus16.grant_idx), 32'(3));
    chk("t5_no_pre", 32'(bus16.preempted), 32'(0));
    bus16.req = 4'b0001;
    tick();
    chk("t5_idx",   32'(bus16.grant_idx),   32'(0));
    chk("t5_pre",   32'(bus16.preempted),   32'(0));
    chk("t5_valid", 32'(bus16.grant_valid), 32'(1));
    chk("t5_grant", 32'(bus16.grant),       32'(4'b0001));

    // Asynchronous reset mid-grant, then restart from channel 0.
    do_reset();
    bus16.req = 4'b0100;
    tick();
    chk("t6_owner2", 32'(bus16.grant_idx), 32'(2));
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_grant", 32'(bus16.grant),       32'(0));
    chk("t6_async_valid", 32'(bus16.grant_valid), 32'(0));
    chk("t6_async_idx",   32'(bus16.grant_idx),   32'(0));
    bus16.req = 4'b1100;
    tick();
    chk("t6_held_valid", 32'(bus16.grant_valid), 32'(0));
    rst = 1'b0;
    tick();
    chk("t6_restart_idx",   32'(bus16.grant_idx),   32'(2));
    chk("t6_restart_grant", 32'(bus16.grant),       32'(4'b0100));
    chk("t6_restart_valid", 32'(bus16.grant_valid), 32'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
